servo_pwm_multi: RTL and testbench
==================================

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 N_CH, default 4, number of servo channels (legal 1..8).
REQ-002 CLK_DIV, default 500, clk cycles per tick (50 MHz -> 10 us tick).
REQ-003 PERIOD_TICKS, default 2000, frame length in ticks (20 ms).
REQ-004 MIN_TICKS, default 100, pulse width at position 0 (1 ms).
REQ-005 SPAN, default 100, maximum position; pulse = MIN_TICKS+SPAN at max (2 ms).
REQ-006 PW, default 8, position field width; SHALL satisfy 2^PW > SPAN.
REQ-007 STEP, default 4, sweep increment per step.
REQ-008 clk  input  1  system clock, 50 MHz; sole clock.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 cfg_we  input  1  config write strobe, one clk wide.
REQ-011 cfg_ch  input  max(1,clog2(N_CH))  target channel.
REQ-012 cfg_mode  input  1  0 = direct hold, 1 = sweep.
REQ-013 cfg_pos  input  PW  direct position / sweep start position.
REQ-014 cfg_rate  input  4  sweep: frames per step minus one (0 -> step every frame).
REQ-015 pwm  output  N_CH  servo pulse outputs, registered.
REQ-016 frame_start  output  1  one-clk pulse at start of every frame.

Function
REQ-017 Prescaler SHALL count 0..CLK_DIV-1 on clk and emit a one-clk tick strobe on wrap; no derived clocks anywhere.
REQ-018 Frame counter SHALL advance 0..PERIOD_TICKS-1 on tick, wrapping to 0; wrap cycle is the frame boundary.
REQ-019 pwm[i] SHALL be high exactly while frame counter < MIN_TICKS + act_pos[i]; all channels rise in the same clk cycle, one clk after frame counter reaches 0.
REQ-020 frame_start SHALL pulse in the same clk cycle pwm rises.
REQ-021 cfg_we SHALL update channel cfg_ch shadow (mode, pos, rate) in one cycle; always accepted, no backpressure.
REQ-022 cfg_pos > SPAN SHALL be clamped to SPAN at write; cfg_ch >= N_CH SHALL be ignored.
REQ-023 Shadow-to-active transfer SHALL occur only at frame boundary; pulse width never changes mid-frame.
REQ-024 Write coinciding with frame boundary SHALL apply to the frame then starting.
REQ-025 Per-channel FSM states: HOLD, UP, DOWN; write with mode 0 -> HOLD at cfg_pos; mode 1 -> UP from cfg_pos, rate counter cleared.
REQ-026 In UP/DOWN, a per-channel frame counter SHALL count boundaries; on reaching cfg_rate, position += / -= STEP and counter clears.
REQ-027 UP: pos+STEP >= SPAN -> pos = SPAN, go DOWN; DOWN: pos <= STEP -> pos = 0, go UP (saturating, no wrap).
REQ-028 Pending shadow write at boundary SHALL override that boundary's sweep step for that channel.
REQ-029 Position arithmetic SHALL be PW+1 bits wide to avoid overflow before clamping.

Reset
REQ-030 rst_n low SHALL immediately force pwm = 0, frame_start = 0, counters = 0, all channels HOLD, positions 0, rates 0.
REQ-031 After rst_n release, first frame SHALL start at once: pwm high one clk later, 1 ms pulses on all channels.
REQ-032 Reset mid-pulse SHALL truncate the pulse asynchronously; shadow writes are discarded.

Structure
REQ-033 Package servo_pkg SHALL hold mode encoding, FSM state enum and default timing constants (50 MHz, 10 us tick, 20 ms frame).
REQ-034 Prescaler SHALL be a sub-module tick_gen(clk, rst_n, tick) parametrised by CLK_DIV; per-channel logic in a generate loop.

Verification
REQ-035 Reset release, defaults -> all pwm high 50_000 clk, period 1_000_000 clk, frame_start each period.
REQ-036 Write ch1 direct pos 50 mid-frame -> current frame unchanged, next frame ch1 = 75_000 clk; others 50_000.
REQ-037 Write ch0 pos 200 -> clamped, 100_000 clk pulse; write cfg_ch 5 with N_CH=4 -> no change.
REQ-038 ch2 sweep pos 0 rate 0 STEP 4 -> widths 0,4,...,96,100,96,... ticks+100 per frame, bounce at 0 and SPAN.
REQ-039 Write ch3 in boundary cycle -> applied to frame starting that cycle; sweep step suppressed for that channel.
REQ-040 rst_n pulsed low mid-pulse -> pwm low same cycle, sweep state HOLD/0 after release.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared encodings and default timing for the servo PWM block (50 MHz clk, 10 us tick, 20 ms frame).
package servo_pkg;

   typedef enum logic {
      MODE_HOLD  = 1'b0,
      MODE_SWEEP = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } sweep_st_e;

   localparam int unsigned CLK_HZ           = 50_000_000;
   localparam int unsigned TICK_US          = 10;
   localparam int unsigned DEF_N_CH         = 4;
   localparam int unsigned DEF_CLK_DIV      = CLK_HZ / 1_000_000 * TICK_US;
   localparam int unsigned DEF_PERIOD_TICKS = 2000;
   localparam int unsigned DEF_MIN_TICKS    = 100;
   localparam int unsigned DEF_SPAN         = 100;
   localparam int unsigned DEF_PW           = 8;
   localparam int unsigned DEF_STEP         = 4;

   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Config write port and PWM outputs of servo_pwm_multi; master drives config, slave is the PWM block.
interface servo_pwm_multi_if
   import servo_pkg::*;
#(
   parameter int N_CH = DEF_N_CH,
   parameter int PW   = DEF_PW
);
   localparam int CH_W = ch_width(N_CH);

   logic             cfg_we;
   logic [CH_W-1:0]  cfg_ch;
   logic             cfg_mode;
   logic [PW-1:0]    cfg_pos;
   logic [3:0]       cfg_rate;
   logic [N_CH-1:0]  pwm;
   logic             frame_start;

   modport master (
      output cfg_we, cfg_ch, cfg_mode, cfg_pos, cfg_rate,
      input  pwm, frame_start
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_mode, cfg_pos, cfg_rate,
      output pwm, frame_start
   );

endinterface

// File: rtl/servo_pwm_multi_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 and strobes tick for one clk on the wrap cycle.
// Latency: tick is decoded from the count register; no backpressure.
module tick_gen #(
   parameter int unsigned CLK_DIV = 500
)(
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(CLK_DIV - 1));
   assign tick   = w_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM with per-channel hold/sweep; pwm rises 1 clk after the frame counter reaches 0.
// Config writes are always accepted and take effect only at the next frame boundary.
module servo_pwm_multi
   import servo_pkg::*;
#(
   parameter int N_CH         = DEF_N_CH,
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
   parameter int MIN_TICKS    = DEF_MIN_TICKS,
   parameter int SPAN         = DEF_SPAN,
   parameter int PW           = DEF_PW,
   parameter int STEP         = DEF_STEP
)(
   input  logic             clk,
   input  logic             rst_n,
   servo_pwm_multi_if.slave bus
);
   localparam int CH_W  = ch_width(N_CH);
   localparam int CNT_W = $clog2(PERIOD_TICKS + MIN_TICKS + SPAN + 1);

   logic             w_tick;
   logic             w_boundary;
   logic [PW-1:0]    w_cfg_pos;
   logic [CNT_W-1:0] r_frame;
   logic             r_at_start;
   logic             r_fs;

   tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   assign w_boundary = w_tick && (r_frame == CNT_W'(PERIOD_TICKS - 1));
   assign w_cfg_pos  = (bus.cfg_pos > PW'(SPAN)) ? PW'(SPAN) : bus.cfg_pos;
   assign bus.frame_start = r_fs;

   // r_at_start marks the first cycle of a frame (frame counter just became 0); reset counts as a boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame    <= '0;
         r_at_start <= 1'b1;
         r_fs       <= 1'b0;
      end else begin
         if (w_tick) begin
            r_frame <= w_boundary ? '0 : r_frame + CNT_W'(1);
         end
         r_at_start <= w_boundary;
         r_fs       <= r_at_start;
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic             w_wr;
      logic             w_ld_mode;
      logic [PW-1:0]    w_ld_pos;
      logic [3:0]       w_ld_rate;
      logic [PW:0]      w_up;
      logic             w_dn_floor;
      logic [CNT_W-1:0] w_thr;

      logic             r_sh_mode;
      logic [PW-1:0]    r_sh_pos;
      logic [3:0]       r_sh_rate;
      logic             r_pend;
      sweep_st_e        r_st;
      logic [PW-1:0]    r_pos;
      logic [3:0]       r_rate;
      logic [3:0]       r_rcnt;
      logic             r_pwm;

      // Out-of-range channel numbers never match any gi, so such writes fall away here.
      assign w_wr       = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));
      assign w_ld_mode  = w_wr ? bus.cfg_mode : r_sh_mode;
      assign w_ld_pos   = w_wr ? w_cfg_pos    : r_sh_pos;
      assign w_ld_rate  = w_wr ? bus.cfg_rate : r_sh_rate;
      assign w_up       = {1'b0, r_pos} + (PW+1)'(STEP);
      assign w_dn_floor = ({1'b0, r_pos} <= (PW+1)'(STEP));
      assign w_thr      = CNT_W'(MIN_TICKS) + CNT_W'(r_pos);
      assign bus.pwm[gi] = r_pwm;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sh_mode <= 1'b0;
            r_sh_pos  <= '0;
            r_sh_rate <= '0;
            r_pend    <= 1'b0;
            r_st      <= ST_HOLD;
            r_pos     <= '0;
            r_rate    <= '0;
            r_rcnt    <= '0;
            r_pwm     <= 1'b0;
         end else begin
            r_pwm <= (r_frame < w_thr);
            if (w_wr) begin
               r_sh_mode <= bus.cfg_mode;
               r_sh_pos  <= w_cfg_pos;
               r_sh_rate <= bus.cfg_rate;
            end
            if (w_boundary) begin
               r_pend <= 1'b0;
               // A pending or same-cycle write replaces this boundary's sweep step.
               if (w_wr || r_pend) begin
                  r_pos  <= w_ld_pos;
                  r_rate <= w_ld_rate;
                  r_rcnt <= '0;
                  r_st   <= (w_ld_mode == MODE_SWEEP) ? ST_UP : ST_HOLD;
               end else if (r_st != ST_HOLD) begin
                  if (r_rcnt != r_rate) begin
                     r_rcnt <= r_rcnt + 4'd1;
                  end else begin
                     r_rcnt <= '0;
                     if (r_st == ST_UP) begin
                        if (w_up >= (PW+1)'(SPAN)) begin
                           r_pos <= PW'(SPAN);
                           r_st  <= ST_DOWN;
                        end else begin
                           r_pos <= w_up[PW-1:0];
                        end
                     end else begin
                        if (w_dn_floor) begin
                           r_pos <= '0;
                           r_st  <= ST_UP;
                        end else begin
                           r_pos <= r_pos - PW'(STEP);
                        end
                     end
                  end
               end
            end else if (w_wr) begin
               r_pend <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with a shortened frame (2 clk/tick, 40-tick frame, 80 clk).
module tb_servo_pwm_multi;

   localparam int N_CH    = 5;
   localparam int CLK_DIV = 2;
   localparam int PERIOD  = 40;
   localparam int MIN_T   = 10;
   localparam int SPAN    = 22;
   localparam int PW      = 8;
   localparam int STEP    = 4;
   localparam int FRAME   = PERIOD * CLK_DIV;
   localparam int MID     = 30;
   localparam int BND     = FRAME - 2;
   localparam int NREC    = 23;

   typedef struct packed {
      logic                 wr;
      logic [2:0]           ch;
      logic                 mode;
      logic [7:0]           pos;
      logic [3:0]           rate;
      logic [6:0]           at;
      logic [N_CH-1:0][7:0] ex;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   servo_pwm_multi_if #(.N_CH(N_CH), .PW(PW)) bus ();

   servo_pwm_multi #(
      .N_CH(N_CH), .CLK_DIV(CLK_DIV), .PERIOD_TICKS(PERIOD), .MIN_TICKS(MIN_T),
      .SPAN(SPAN), .PW(PW), .STEP(STEP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   rec_t tbl [NREC];
   int   meas_w [N_CH];
   int   meas_fs;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic rec_t mk(input int wr, input int ch, input int mode, input int pos,
                               input int rate, input int at, input int e0, input int e1,
                               input int e2, input int e3, input int e4);
      rec_t m;
      m.wr = 1'(wr); m.ch = 3'(ch); m.mode = 1'(mode); m.pos = 8'(pos);
      m.rate = 4'(rate); m.at = 7'(at);
      m.ex[0] = 8'(e0); m.ex[1] = 8'(e1); m.ex[2] = 8'(e2); m.ex[3] = 8'(e3); m.ex[4] = 8'(e4);
      return m;
   endfunction

   task automatic set_cfg(input logic we, input int ch, input logic mode, input int pos, input int rate);
      bus.cfg_we   = we;
      bus.cfg_ch   = 3'(ch);
      bus.cfg_mode = mode;
      bus.cfg_pos  = 8'(pos);
      bus.cfg_rate = 4'(rate);
   endtask

   task automatic wait_fs(input int limit, output int n);
      n = -1;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (bus.frame_start === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   // Called on the negedge of a frame's first cycle; returns on the next frame's first cycle.
   task automatic run_frame(input rec_t r);
      for (int k = 0; k < N_CH; k++) meas_w[k] = 0;
      meas_fs = 0;
      for (int c = 0; c < FRAME; c++) begin
         for (int k = 0; k < N_CH; k++) if (bus.pwm[k] === 1'b1) meas_w[k]++;
         if (bus.frame_start === 1'b1) meas_fs++;
         if (r.wr && c == int'(r.at)) set_cfg(1'b1, int'(r.ch), r.mode, int'(r.pos), int'(r.rate));
         else bus.cfg_we = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input string tag, input rec_t r);
      for (int k = 0; k < N_CH; k++)
         check($sformatf("%s_ch%0d_width", tag, k), meas_w[k], (MIN_T + int'(r.ex[k])) * CLK_DIV);
      check($sformatf("%s_fs_count", tag), meas_fs, 1);
      check($sformatf("%s_next_fs", tag), int'(bus.frame_start), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      rec_t idle;
      set_cfg(1'b0, 0, 1'b0, 0, 0);
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      tbl[0]  = mk(0, 0, 0,   0, 0, 0,   0,  0,  0,  0,  0);
      tbl[1]  = mk(1, 1, 0,  11, 0, MID, 0,  0,  0,  0,  0);
      tbl[2]  = mk(1, 0, 0, 200, 0, MID, 0,  11, 0,  0,  0);
      tbl[3]  = mk(1, 6, 0,   5, 0, MID, 22, 11, 0,  0,  0);
      tbl[4]  = mk(1, 2, 1,   0, 0, MID, 22, 11, 0,  0,  0);
      tbl[5]  = mk(1, 4, 1,  20, 1, MID, 22, 11, 0,  0,  0);
      tbl[6]  = mk(1, 3, 1,   8, 0, BND, 22, 11, 4,  0,  20);
      tbl[7]  = mk(0, 0, 0,   0, 0, 0,   22, 11, 8,  8,  20);
      tbl[8]  = mk(0, 0, 0,   0, 0, 0,   22, 11, 12, 12, 22);
      tbl[9]  = mk(1, 3, 1,   8, 0, BND, 22, 11, 16, 16, 22);
      tbl[10] = mk(0, 0, 0,   0, 0, 0,   22, 11, 20, 8,  18);
      tbl[11] = mk(1, 3, 0,   3, 0, BND, 22, 11, 22, 12, 18);
      tbl[12] = mk(0, 0, 0,   0, 0, 0,   22, 11, 18, 3,  14);
      tbl[13] = mk(0, 0, 0,   0, 0, 0,   22, 11, 14, 3,  14);
      tbl[14] = mk(0, 0, 0,   0, 0, 0,   22, 11, 10, 3,  10);
      tbl[15] = mk(0, 0, 0,   0, 0, 0,   22, 11, 6,  3,  10);
      tbl[16] = mk(0, 0, 0,   0, 0, 0,   22, 11, 2,  3,  6);
      tbl[17] = mk(0, 0, 0,   0, 0, 0,   22, 11, 0,  3,  6);
      tbl[18] = mk(0, 0, 0,   0, 0, 0,   22, 11, 4,  3,  2);
      tbl[19] = mk(0, 0, 0,   0, 0, 0,   22, 11, 8,  3,  2);
      tbl[20] = mk(0, 0, 0,   0, 0, 0,   22, 11, 12, 3,  0);
      tbl[21] = mk(0, 0, 0,   0, 0, 0,   22, 11, 16, 3,  0);
      tbl[22] = mk(0, 0, 0,   0, 0, 0,   22, 11, 20, 3,  4);

      repeat (3) @(negedge clk);
      check("reset_pwm", int'(bus.pwm), 0);
      check("reset_fs", int'(bus.frame_start), 0);
      rst_n = 1'b1;
      wait_fs(3 * FRAME, n);
      check("first_fs_delay", n, 0);
      check("first_pwm_all_high", int'(bus.pwm), (1 << N_CH) - 1);

      for (int f = 0; f < NREC; f++) begin
         run_frame(tbl[f]);
         check_frame($sformatf("f%0d", f), tbl[f]);
      end

      // Mid-pulse reset with a pending write: pulse cut at once, write and sweep state lost.
      for (int c = 0; c < 10; c++) begin
         if (c == 3) set_cfg(1'b1, 1, 1'b0, 5, 0);
         else bus.cfg_we = 1'b0;
         @(negedge clk);
      end
      check("pre_reset_pwm", int'(bus.pwm), (1 << N_CH) - 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_pwm", int'(bus.pwm), 0);
      check("async_reset_fs", int'(bus.frame_start), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_fs(3 * FRAME, n);
      check("rerelease_fs_delay", n, 0);
      run_frame(idle);
      check_frame("post_rst0", idle);
      run_frame(idle);
      check_frame("post_rst1", idle);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
